// File: rtl/countdown_setter.sv
// countdown_setter: debounced panel keys drive a field-select FSM that edits a BCD h:m:s preset
// and hands it to the countdown via a one-cycle PE strobe, plus a run/pause CE level.
module countdown_setter #(
  parameter logic [19:0] DB_CYCLES  = 20'd500000,
  parameter logic [24:0] RPT_DELAY  = 25'd25000000,
  parameter logic [24:0] RPT_PERIOD = 25'd5000000
) (
  input  logic       CP,
  input  logic       CR_n,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  input  logic       KEY_DEC,
  input  logic       KEY_RUN,
  output logic [7:0] D_H,
  output logic [7:0] D_M,
  output logic [7:0] D_S,
  output logic       PE,
  output logic       CE,
  output logic [2:0] SEL
);
  localparam logic [1:0] IDLE = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3;
  logic [3:0] raw, ev;
  logic [1:0] st;
  assign raw = {KEY_RUN, KEY_DEC, KEY_INC, KEY_MODE};
  for (genvar i = 0; i < 4; i++) begin : g_key
    logic s1, s2, lvl, lvl_d, ev_r, rep;
    logic [19:0] cnt;
    always_ff @(posedge CP or negedge CR_n)
      if (!CR_n) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
        ev_r  <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= raw[i];
        s2    <= s1;
        cnt   <= (s2 == lvl || cnt == DB_CYCLES - 20'd1) ? '0 : cnt + 20'd1;
        lvl   <= (s2 != lvl && cnt == DB_CYCLES - 20'd1) ? s2 : lvl;
        lvl_d <= lvl;
        ev_r  <= lvl & ~lvl_d | rep;
      end
    assign ev[i] = ev_r;
    // only INC and DEC auto-repeat; rph marks that the initial delay has elapsed
    if (i == 1 || i == 2) begin : g_rpt
      logic [24:0] rcnt;
      logic rph;
      assign rep = lvl && rcnt == (rph ? RPT_PERIOD : RPT_DELAY) - 25'd1;
      always_ff @(posedge CP or negedge CR_n)
        if (!CR_n) begin
          rcnt <= '0;
          rph  <= 1'b0;
        end else begin
          rcnt <= (!lvl || rep) ? '0 : rcnt + 25'd1;
          rph  <= lvl & (rph | rep);
        end
    end else begin : g_norpt
      assign rep = 1'b0;
    end
  end
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up, input logic [7:0] top);
    return up ? (v == top ? 8'h00 : v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01)
              : (v == 8'h00 ? top : v[3:0] == 4'h0 ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01);
  endfunction
  // priority: RUN over MODE over INC/DEC; INC with DEC cancels
  always_ff @(posedge CP or negedge CR_n)
    if (!CR_n) begin
      st  <= IDLE;
      D_H <= 8'h00;
      D_M <= 8'h00;
      D_S <= 8'h00;
      PE  <= 1'b0;
      CE  <= 1'b0;
    end else begin
      PE <= ev[3] && st != IDLE;
      if (ev[3]) begin
        st <= IDLE;
        CE <= (st == IDLE) ? ~CE : CE;
      end else if (ev[0]) begin
        st <= st + 2'd1;
        CE <= (st == IDLE) ? 1'b0 : CE;
      end else if (st != IDLE && (ev[1] ^ ev[2])) begin
        D_H <= (st == SET_H) ? bcd_step(D_H, ev[1], 8'h23) : D_H;
        D_M <= (st == SET_M) ? bcd_step(D_M, ev[1], 8'h59) : D_M;
        D_S <= (st == SET_S) ? bcd_step(D_S, ev[1], 8'h59) : D_S;
      end
    end
  assign SEL = (st == SET_H) ? 3'b100 : (st == SET_M) ? 3'b010 : (st == SET_S) ? 3'b001 : 3'b000;
endmodule
